// File: rtl/toy_cipher_decrypt_core_if.sv
// Handshake bundle for the toy cipher decrypt core: request side (key/ciphertext) and response side (plaintext).
// Latency: n/a (wiring only).
// Backpressure: in_ready gates requests, out_ready holds the response until taken.
// Signals: in_valid/in_ready/key/ciphertext (request), out_valid/out_ready/plaintext (response), busy (status).
interface toy_cipher_decrypt_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  // Requester / consumer side.
  modport master (
    output in_valid, key, ciphertext, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );

  // Decrypt core side.
  modport slave (
    input  in_valid, key, ciphertext, out_ready,
    output in_ready, out_valid, plaintext, busy
  );
endinterface

// File: rtl/toy_cipher_decrypt_core.sv
// Iterative decryptor for the 128-bit toy block cipher: key expansion then one inverse round per cycle.
// Latency: accept edge to out_valid edge = (ROUNDS-1)+ROUNDS on a key-cache miss, ROUNDS on a hit.
// Backpressure: in_ready only in IDLE; plaintext/out_valid held in DONE until out_ready.
// Ports: clk, rst (async active-high), bus (slave modport of toy_cipher_decrypt_core_if).
module toy_cipher_decrypt_core #(
  parameter int         ROUNDS    = 10,
  parameter logic [7:0] SUB_CONST = 8'h55
) (
  input  logic                       clk,
  input  logic                       rst,
  toy_cipher_decrypt_core_if.slave   bus
);

  localparam int            CW   = $clog2(ROUNDS);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t         state_q, state_d;
  logic [127:0]   s_q, s_d;
  logic [127:0]   rk_q [ROUNDS];
  logic [127:0]   rk_d [ROUNDS];
  logic [CW-1:0]  kcnt_q, kcnt_d;
  logic [CW-1:0]  rcnt_q, rcnt_d;
  logic [127:0]   ckey_q, ckey_d;
  logic           cvalid_q, cvalid_d;
  logic [127:0]   pt_q, pt_d;
  logic           ov_q, ov_d;

  // Next round key: the low byte, whitened with SUB_CONST, is spread over the low 64 bits.
  function automatic logic [127:0] next_rk(input logic [127:0] prev);
    return prev ^ {64'h0, {8{prev[7:0] ^ SUB_CONST}}};
  endfunction

  // One inverse round. The forward mix s ^= s<<1 is undone by a prefix XOR from the LSB.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk);
    logic [127:0] t;
    logic [127:0] x;
    t    = s ^ rk;
    x[0] = t[0];
    for (int i = 1; i < 128; i++) x[i] = t[i] ^ x[i-1];
    return {x[7:0], x[127:8]} ^ {16{SUB_CONST}};
  endfunction

  logic [127:0] round_out;
  assign round_out = inv_round(s_q, rk_q[rcnt_q]);

  // in_ready is forced low while reset is held even though the state already reads IDLE.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = ov_q;
  assign bus.plaintext = pt_q;
  assign bus.busy      = (state_q == KEYEXP) || (state_q == ROUND);

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    rk_d     = rk_q;
    kcnt_d   = kcnt_q;
    rcnt_d   = rcnt_q;
    ckey_d   = ckey_q;
    cvalid_d = cvalid_q;
    pt_d     = pt_q;
    ov_d     = ov_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.ciphertext;
          rk_d[0] = bus.key;
          if (cvalid_q && (bus.key == ckey_q)) begin
            // Round keys from the previous block are still valid.
            state_d = ROUND;
            rcnt_d  = LAST;
          end else begin
            // Cache stays invalid until the whole schedule has been written.
            state_d  = KEYEXP;
            kcnt_d   = ONE;
            ckey_d   = bus.key;
            cvalid_d = 1'b0;
          end
        end
      end
      KEYEXP: begin
        rk_d[kcnt_q] = next_rk(rk_q[kcnt_q - ONE]);
        if (kcnt_q == LAST) begin
          cvalid_d = 1'b1;
          state_d  = ROUND;
          rcnt_d   = LAST;
        end else begin
          kcnt_d = kcnt_q + ONE;
        end
      end
      ROUND: begin
        s_d = round_out;
        if (rcnt_q == '0) begin
          pt_d    = round_out;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          rcnt_d = rcnt_q - ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      rk_q     <= '{default: '0};
      kcnt_q   <= '0;
      rcnt_q   <= '0;
      ckey_q   <= '0;
      cvalid_q <= 1'b0;
      pt_q     <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      rk_q     <= rk_d;
      kcnt_q   <= kcnt_d;
      rcnt_q   <= rcnt_d;
      ckey_q   <= ckey_d;
      cvalid_q <= cvalid_d;
      pt_q     <= pt_d;
      ov_q     <= ov_d;
    end
  end

endmodule

// File: tb/tb_toy_cipher_decrypt_core.sv
// Bench for toy_cipher_decrypt_core: encrypts vectors with a forward-cipher model and
// expects the core to recover the plaintext with the right latency and handshake behaviour.
module tb_toy_cipher_decrypt_core;

  logic clk;
  logic rst;

  toy_cipher_decrypt_core_if bus ();

  toy_cipher_decrypt_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] sb_q [$];

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] KEY_C = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  // Forward cipher model.
  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] rk [10];
    logic [127:0] s;
    rk[0] = k;
    for (int i = 1; i < 10; i++) rk[i] = rk[i-1] ^ {64'h0, {8{rk[i-1][7:0] ^ 8'h55}}};
    s = p;
    for (int r = 0; r < 10; r++) begin
      s = s ^ {16{8'h55}};
      s = {s[119:0], s[127:120]};
      s = s ^ (s << 1);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  // Offer one block at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [127:0] k, input logic [127:0] p, input string name);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
    end
    bus.key        = k;
    bus.ciphertext = enc(k, p);
    bus.in_valid   = 1'b1;
    sb_q.push_back(p);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy after accept: got %b want 1", name, bus.busy);
    end
  endtask

  // Count edges until out_valid, then score latency and plaintext.
  task automatic wait_out(input int exp_lat, input string name);
    int lat;
    logic [127:0] exp_pt;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, lat);
      return;
    end
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard empty at output", name);
    end else begin
      exp_pt = sb_q.pop_front();
      if (bus.plaintext !== exp_pt) begin
        n_err++;
        $display("FAIL %s plaintext: got %h want %h", name, bus.plaintext, exp_pt);
      end
    end
  endtask

  // Complete the output handshake; out_valid must drop and in_ready return one cycle later.
  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s after handshake: out_valid=%b in_ready=%b want 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.plaintext !== 128'h0) begin
      n_err++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b pt=%h want 0/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.plaintext);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_miss();
    send(KEY_A, 128'h00112233445566778899aabbccddeeff, "miss");
    wait_out(19, "miss");
    drain("miss");
  endtask

  task automatic test_hit();
    send(KEY_A, {128{1'b1}}, "hit");
    wait_out(10, "hit");
    drain("hit");
  endtask

  // Zero vector with out_ready held high in advance, then a new key forces key expansion.
  task automatic test_zero();
    bus.out_ready = 1'b1;
    send(128'h0, 128'h0, "zero");
    wait_out(19, "zero");
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_eager out_valid width: got %b want 0 one cycle later", bus.out_valid);
    end
    send(KEY_B, 128'h0123456789abcdef0011223344556677, "newkey");
    wait_out(19, "newkey");
    drain("newkey");
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    send(KEY_B, 128'hcafef00dcafef00d5555aaaa5555aaaa, "bp");
    wait_out(10, "bp");
    held = bus.plaintext;
    for (int i = 0; i < 5; i++) begin
      bus.key        = KEY_A;
      bus.ciphertext = 128'h1;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.plaintext !== held) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b pt=%h want 1/0/%h",
                 i, bus.out_valid, bus.in_ready, bus.plaintext, held);
      end
    end
    drain("bp");
    // Ignored pulses must not have disturbed the key cache.
    send(KEY_B, 128'h00000000000000000000000000000001, "bp_after");
    wait_out(10, "bp_after");
    drain("bp_after");
  endtask

  task automatic test_mid_reset();
    send(KEY_B, 128'h13579bdf02468ace13579bdf02468ace, "midrst");
    void'(sb_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.plaintext !== 128'h0) begin
      n_err++;
      $display("FAIL midrst outputs: out_valid=%b busy=%b pt=%h want 0/0/0", bus.out_valid, bus.busy, bus.plaintext);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    send(KEY_B, 128'h2468ace013579bdf2468ace013579bdf, "midrst_again");
    wait_out(19, "midrst_again");
    drain("midrst_again");
  endtask

  task automatic test_post_reset_cache();
    send(KEY_C, 128'h89abcdef0123456789abcdef01234567, "prc_first");
    wait_out(19, "prc_first");
    drain("prc_first");
    do_reset();
    send(KEY_C, 128'h76543210fedcba9876543210fedcba98, "prc_second");
    wait_out(19, "prc_second");
    drain("prc_second");
  endtask

  task automatic test_random();
    logic [127:0] k;
    logic [127:0] p;
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      send(k, p, "rand_miss");
      wait_out(19, "rand_miss");
      drain("rand_miss");
      send(k, ~p, "rand_hit");
      wait_out(10, "rand_hit");
      drain("rand_hit");
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.key        = '0;
    bus.ciphertext = '0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_miss();
    test_hit();
    test_zero();
    test_backpressure();
    test_mid_reset();
    test_post_reset_cache();
    test_random();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/toy_cipher_decrypt_core.md
# toy_cipher_decrypt_core

Iterative decryption engine for the team's 128-bit toy block cipher, the inverse of the existing toy encryption core. It accepts a key/ciphertext pair on a valid/ready handshake, expands the round keys, runs the inverse rounds one per cycle, and returns the plaintext on a second valid/ready handshake. It sits beside the encryption core in the crypto test harness and is used to round-trip vectors and to exercise weak-cipher detection flows.

## Interface
- ROUNDS, 10, number of cipher rounds; round keys rk[0..ROUNDS-1] are used.
- SUB_CONST, 8'h55, byte constant used by the substitution layer and the key schedule.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  key/ciphertext offered.
- in_ready  out  1  core can accept; high only in IDLE.
- key  in  128  cipher key; sampled when in_valid && in_ready.
- ciphertext  in  128  block to decrypt; sampled with key.
- out_valid  out  1  plaintext valid; held until accepted.
- out_ready  in  1  consumer accepts plaintext.
- plaintext  out  128  recovered block.
- busy  out  1  high in KEYEXP or ROUND.

## Operation
- Forward cipher being inverted: round r = 0..ROUNDS-1: s ^= {16{SUB_CONST}}; s = {s[119:0], s[127:120]}; s ^= (s << 1), zero-filled, truncated to 128 bits; s ^= rk[r].
- Key schedule: rk[0] = key; rk[i] = rk[i-1] ^ {64'h0, {8{rk[i-1][7:0] ^ SUB_CONST}}}, i = 1..ROUNDS-1.
- Inverse round r, for r = ROUNDS-1 down to 0:
  - s ^= rk[r].
  - Un-mix by prefix XOR from the LSB: x[0] = s[0]; x[i] = s[i] ^ x[i-1]. This is a combinational 128-bit chain.
  - Rotate right by 8: s = {x[7:0], x[127:8]}.
  - s ^= {16{SUB_CONST}}.
- Round keys are stored in a ROUNDS x 128 register array.
- Key cache: a cached key register plus a cache_valid flag.
  - On accept, if cache_valid and key equals the cached key, KEYEXP is skipped.
  - Otherwise the cache is reloaded and KEYEXP runs.
- FSM states:
  - IDLE: in_ready = 1. On accept, load s <= ciphertext and rk[0] <= key. Go to KEYEXP with kcnt = 1 on a cache miss, or to ROUND with rcnt = ROUNDS-1 on a hit.
  - KEYEXP: each cycle computes rk[kcnt] from rk[kcnt-1] and increments kcnt. After kcnt = ROUNDS-1 is written, set cache_valid and go to ROUND with rcnt = ROUNDS-1.
  - ROUND: each cycle applies inverse round rcnt to s. At rcnt = 0, register the result into plaintext, set out_valid, and go to DONE. Otherwise decrement rcnt.
  - DONE: out_valid = 1 and plaintext stable. On out_ready, clear out_valid and go to IDLE.
- Inputs offered outside IDLE are ignored, because in_ready = 0.

## Timing
- Reset values: in_ready = 0 while rst is asserted, then 1 (IDLE); out_valid = 0; busy = 0; plaintext = 0; state = IDLE; cache_valid = 0; counters = 0. Round-key and state registers are cleared to 0.
- Reset mid-operation (any state) aborts immediately. No out_valid is produced for the aborted block. The cache is invalidated, so the next accept always runs KEYEXP.
- Latency, counting from the accept edge to the edge that sets out_valid:
  - Cache miss: (ROUNDS-1) + ROUNDS = 19 cycles.
  - Cache hit: ROUNDS = 10 cycles.
- out_valid and out_ready high in the same cycle: the transfer completes at that edge, and in_ready rises the next cycle. Minimum initiation interval on a miss is 21 cycles (accept, 19, handshake, back to IDLE).
- out_ready held high before out_valid rises: out_valid still stays high for exactly one cycle.
- Counters wrap-free: kcnt spans 1..ROUNDS-1 and rcnt spans ROUNDS-1..0; no other values are reachable.

## Test plan
- Reset: assert rst mid-ROUND -> out_valid = 0, busy = 0, plaintext = 0 on the same cycle. After release, in_ready = 1.
- Round trip, cache miss: key = 128'h000102030405060708090a0b0c0d0e0f. Ciphertext is encryptor(key, 128'h00112233445566778899aabbccddeeff). Expect plaintext = 128'h00112233445566778899aabbccddeeff with out_valid rising 19 cycles after accept.
- Cache hit: same key, ciphertext for plaintext 128'hffffffffffffffffffffffffffffffff. Expect the correct plaintext 10 cycles after accept.
- Zero vector: key = 0, ciphertext = encryptor(0, 0). Expect plaintext = 0. Repeating with a different key forces KEYEXP again (19-cycle latency).
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid. Plaintext and out_valid stay stable, in_ready = 0, and in_valid pulses are ignored. Asserting out_ready returns the core to IDLE the next cycle.
- Post-reset cache: decrypt with key K, reset, decrypt again with K. The second decrypt takes 19 cycles, not 10.
